// File: rtl/nova_mmu_pkg.sv
// Shared types and default geometry for the page cache MMU.
// Optional hit/miss statistics are built only when CACHE_STATS_EN is defined.
package nova_mmu_pkg;

    typedef enum logic {
        RUN = 1'b0,
        REQ = 1'b1
    } state_t;

    localparam int unsigned DEF_ENTRIES      = 8;
    localparam int unsigned DEF_ADDR_W       = 24;
    localparam int unsigned DEF_PAGE_W       = 10;
    localparam int unsigned DEF_CYCLE_LEN    = 10;
    localparam int unsigned DEF_PHI2_LOW_LEN = 5;
    localparam int unsigned DEF_LATCH_AT     = 7;
    localparam int unsigned STAT_W           = 16;

endpackage

// File: rtl/page_cache_mmu_if.sv
// CPU bus / SRAM / page-loader signal bundle of the page cache MMU.
// hitCount and missCount exist only when CACHE_STATS_EN is defined.
interface page_cache_mmu_if
    import nova_mmu_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned PAGE_W = DEF_PAGE_W,
    parameter int unsigned IDX_W  = $clog2(DEF_ENTRIES)
);
    logic [ADDR_W-1:0]        a;
    logic                     flush;
    logic                     phi2;
    logic                     sramEn;
    logic [IDX_W+PAGE_W-1:0]  sramAddr;
    logic                     refillReq;
    logic [ADDR_W-PAGE_W-1:0] refillTag;
    logic [IDX_W-1:0]         refillSlot;
    logic                     refillAck;
`ifdef CACHE_STATS_EN
    logic [STAT_W-1:0]        hitCount;
    logic [STAT_W-1:0]        missCount;

    modport master (output a, flush, refillAck,
                    input  phi2, sramEn, sramAddr, refillReq, refillTag, refillSlot,
                           hitCount, missCount);
    modport slave  (input  a, flush, refillAck,
                    output phi2, sramEn, sramAddr, refillReq, refillTag, refillSlot,
                           hitCount, missCount);
`else
    modport master (output a, flush, refillAck,
                    input  phi2, sramEn, sramAddr, refillReq, refillTag, refillSlot);
    modport slave  (input  a, flush, refillAck,
                    output phi2, sramEn, sramAddr, refillReq, refillTag, refillSlot);
`endif

endinterface

// File: rtl/page_tag_cam.sv
// Fully associative valid/tag array: parallel compare, lowest-index encode,
// lowest-free-slot search, single-entry install and whole-table flush.
module page_tag_cam #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned TAG_W   = 14,
    localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit_c,
    output logic [IDX_W-1:0] hit_idx_c,
    output logic             free_any_c,
    output logic [IDX_W-1:0] free_idx_c,
    input  logic             install_en,
    input  logic [IDX_W-1:0] install_idx,
    input  logic [TAG_W-1:0] install_tag,
    input  logic             flush
);
    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags [ENTRIES];
    logic [ENTRIES-1:0] match;

    always_comb begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
            match[i] = valid[i] && (tags[i] == lookup_tag);
        end
    end

    // Scan high to low so the lowest matching / free index is the one left standing
    always_comb begin
        hit_idx_c  = '0;
        free_idx_c = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (match[i]) hit_idx_c = IDX_W'(i);
            if (!valid[i]) free_idx_c = IDX_W'(i);
        end
    end

    assign hit_c      = |match;
    assign free_any_c = ~&valid;

    // Flush first, then the install, so a same-cycle install survives the flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (flush) valid <= '0;
            if (install_en) valid[install_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (install_en) tags[install_idx] <= install_tag;
    end

endmodule

// File: rtl/page_cache_mmu.sv
// Page cache MMU: phi2 sequencer, address latch, tag lookup and refill handshake.
// Define CACHE_STATS_EN to build the saturating hit/miss counters.
module page_cache_mmu
    import nova_mmu_pkg::*;
#(
    parameter int unsigned ENTRIES      = DEF_ENTRIES,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned PAGE_W       = DEF_PAGE_W,
    parameter int unsigned CYCLE_LEN    = DEF_CYCLE_LEN,
    parameter int unsigned PHI2_LOW_LEN = DEF_PHI2_LOW_LEN,
    parameter int unsigned LATCH_AT     = DEF_LATCH_AT
) (
    input  logic            fpgaClk,
    input  logic            reset,
    page_cache_mmu_if.slave bus
);
    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned TAG_W  = ADDR_W - PAGE_W;
    localparam int unsigned PH_W   = $clog2(CYCLE_LEN);
    localparam int unsigned LOOKUP = LATCH_AT + 1;

    state_t                   state;
    logic [PH_W-1:0]          phase;
    logic [PH_W-1:0]          phase_nxt;
    logic [ADDR_W-1:0]        a_lat;
    logic [TAG_W-1:0]         tag_lat;
    logic                     settle;
    logic [IDX_W-1:0]         victim;
    logic                     victim_used;

    logic                     phi2;
    logic                     sram_en;
    logic [IDX_W+PAGE_W-1:0]  sram_addr;
    logic                     refill_req;
    logic [TAG_W-1:0]         refill_tag;
    logic [IDX_W-1:0]         refill_slot;

    logic                     cam_hit;
    logic [IDX_W-1:0]         cam_hit_idx;
    logic                     cam_free_any;
    logic [IDX_W-1:0]         cam_free_idx;
    logic                     at_lookup;
    logic                     do_lookup;
    logic                     lookup_hit;
    logic                     lookup_miss;
    logic                     install;

    assign tag_lat     = a_lat[ADDR_W-1:PAGE_W];
    assign at_lookup   = (phase == PH_W'(LOOKUP));
    assign do_lookup   = (state == RUN) && at_lookup && !settle;
    assign lookup_hit  = do_lookup && cam_hit;
    assign lookup_miss = do_lookup && !cam_hit;
    assign install     = (state == REQ) && bus.refillAck;

    page_tag_cam #(
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W)
    ) u_cam (
        .clk         (fpgaClk),
        .rst         (reset),
        .lookup_tag  (tag_lat),
        .hit_c       (cam_hit),
        .hit_idx_c   (cam_hit_idx),
        .free_any_c  (cam_free_any),
        .free_idx_c  (cam_free_idx),
        .install_en  (install),
        .install_idx (refill_slot),
        .install_tag (refill_tag),
        .flush       (bus.flush)
    );

    // Phase stalls at LOOKUP while a refill is pending and for the settle cycle after it
    always_comb begin
        phase_nxt = phase;
        if (state == RUN && !(at_lookup && (settle || !cam_hit))) begin
            phase_nxt = (phase == PH_W'(CYCLE_LEN - 1)) ? '0 : phase + PH_W'(1);
        end
    end

    always_ff @(posedge fpgaClk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            phase       <= '0;
            phi2        <= 1'b0;
            a_lat       <= '0;
            settle      <= 1'b0;
            victim      <= '0;
            victim_used <= 1'b0;
            sram_en     <= 1'b0;
            sram_addr   <= '0;
            refill_req  <= 1'b0;
            refill_tag  <= '0;
            refill_slot <= '0;
        end else begin
            phase   <= phase_nxt;
            phi2    <= (phase_nxt >= PH_W'(PHI2_LOW_LEN));
            sram_en <= lookup_hit || (sram_en && (phase_nxt != '0));
            if (phase == PH_W'(LATCH_AT)) a_lat <= bus.a;
            if (lookup_hit) sram_addr <= {cam_hit_idx, a_lat[PAGE_W-1:0]};
            if (settle) settle <= 1'b0;

            case (state)
                RUN: begin
                    if (lookup_miss) begin
                        state       <= REQ;
                        refill_req  <= 1'b1;
                        refill_tag  <= tag_lat;
                        refill_slot <= cam_free_any ? cam_free_idx : victim;
                        victim_used <= !cam_free_any;
                    end
                end
                REQ: begin
                    if (bus.refillAck) begin
                        state      <= RUN;
                        refill_req <= 1'b0;
                        settle     <= 1'b1;
                        if (victim_used) victim <= victim + IDX_W'(1);
                    end
                end
                default: state <= RUN;
            endcase

            if (bus.flush) victim <= '0;
        end
    end

`ifdef CACHE_STATS_EN
    logic              retry;
    logic [STAT_W-1:0] hit_count;
    logic [STAT_W-1:0] miss_count;

    // The re-lookup that follows a refill is excluded from both counters
    always_ff @(posedge fpgaClk or posedge reset) begin
        if (reset) begin
            retry      <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (install) retry <= 1'b1;
            else if (do_lookup) retry <= 1'b0;
            if (lookup_hit && !retry && hit_count != {STAT_W{1'b1}})
                hit_count <= hit_count + STAT_W'(1);
            if (lookup_miss && !retry && miss_count != {STAT_W{1'b1}})
                miss_count <= miss_count + STAT_W'(1);
        end
    end

    assign bus.hitCount  = hit_count;
    assign bus.missCount = miss_count;
`endif

    assign bus.phi2       = phi2;
    assign bus.sramEn     = sram_en;
    assign bus.sramAddr   = sram_addr;
    assign bus.refillReq  = refill_req;
    assign bus.refillTag  = refill_tag;
    assign bus.refillSlot = refill_slot;

endmodule

// File: tb/tb_page_cache_mmu.sv
// Self-checking bench for page_cache_mmu: bus-cycle level reference model of the
// page table, directed scenarios plus randomized traffic; honours CACHE_STATS_EN.
module tb_page_cache_mmu;
    localparam int unsigned ENTRIES = 8;
    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned PAGE_W  = 10;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned TAG_W   = 14;

    logic fpgaClk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // Reference page table: what the spec says the table holds after each bus cycle
    bit               m_valid [ENTRIES];
    logic [TAG_W-1:0] m_tag   [ENTRIES];
    int               m_ptr;
    int               m_hits;
    int               m_misses;

    always #5 fpgaClk = ~fpgaClk;

    page_cache_mmu_if #(.ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .IDX_W(IDX_W)) bus ();

    page_cache_mmu #(
        .ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .PAGE_W(PAGE_W),
        .CYCLE_LEN(10), .PHI2_LOW_LEN(5), .LATCH_AT(7)
    ) dut (
        .fpgaClk (fpgaClk),
        .reset   (reset),
        .bus     (bus)
    );

    function automatic void model_flush();
        for (int i = 0; i < int'(ENTRIES); i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endfunction

    function automatic void model_reset();
        model_flush();
        m_hits   = 0;
        m_misses = 0;
    endfunction

    task automatic check_reset_values(input string tag);
        checks++;
        if (bus.phi2 !== 1'b0 || bus.sramEn !== 1'b0 || bus.sramAddr !== '0 ||
            bus.refillReq !== 1'b0 || bus.refillTag !== '0 || bus.refillSlot !== '0) begin
            errors++;
            $display("FAIL %s: phi2=%b sramEn=%b sramAddr=%h refillReq=%b refillTag=%h refillSlot=%0d, all must be 0",
                     tag, bus.phi2, bus.sramEn, bus.sramAddr, bus.refillReq, bus.refillTag, bus.refillSlot);
        end
`ifdef CACHE_STATS_EN
        checks++;
        if (bus.hitCount !== 16'd0 || bus.missCount !== 16'd0) begin
            errors++;
            $display("FAIL %s_counters: hit=%0d miss=%0d, required 0/0", tag, bus.hitCount, bus.missCount);
        end
`endif
    endtask

    // One full bus cycle starting at the negedge of phase 0; checks every clock of it.
    task automatic access(input logic [ADDR_W-1:0] addr, input int d, input bit flush_first,
                          input bit flush_at_ack, input int reset_at);
        logic [TAG_W-1:0]        tag;
        logic [IDX_W+PAGE_W-1:0] exp_addr;
        bit                      hit;
        bit                      used_ptr;
        int                      slot;
        int                      len;

        tag   = addr[ADDR_W-1:PAGE_W];
        bus.a = addr;
        if (flush_first) begin
            bus.flush = 1'b1;
            model_flush();
        end

        hit = 1'b0; slot = 0; used_ptr = 1'b0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--)
            if (m_valid[i] && m_tag[i] == tag) begin hit = 1'b1; slot = i; end
        if (!hit) begin
            used_ptr = 1'b1; slot = m_ptr;
            for (int i = int'(ENTRIES) - 1; i >= 0; i--)
                if (!m_valid[i]) begin slot = i; used_ptr = 1'b0; end
        end
        if (hit) m_hits++; else m_misses++;
        len      = hit ? 10 : 10 + d + 3;
        exp_addr = {IDX_W'(slot), addr[PAGE_W-1:0]};

        for (int n = 0; n < len; n++) begin
            if (n > 0) @(negedge fpgaClk);
            if (n == 1) bus.flush = 1'b0;
            checks++;
            if (bus.phi2 !== (n >= 5)) begin
                errors++;
                $display("FAIL phi2 addr=%h n=%0d: got %b, required %b", addr, n, bus.phi2, n >= 5);
            end
            checks++;
            if (bus.sramEn !== (n == len - 1)) begin
                errors++;
                $display("FAIL sramEn addr=%h n=%0d: got %b, required %b", addr, n, bus.sramEn, n == len - 1);
            end
            checks++;
            if (bus.refillReq !== (!hit && n >= 9 && n <= 9 + d)) begin
                errors++;
                $display("FAIL refillReq addr=%h n=%0d: got %b, required %b", addr, n, bus.refillReq,
                         !hit && n >= 9 && n <= 9 + d);
            end
            if (!hit && n >= 9 && n <= 9 + d) begin
                checks++;
                if (bus.refillTag !== tag || bus.refillSlot !== IDX_W'(slot)) begin
                    errors++;
                    $display("FAIL refill_payload addr=%h n=%0d: got tag %h slot %0d, required tag %h slot %0d",
                             addr, n, bus.refillTag, bus.refillSlot, tag, slot);
                end
            end
            if (n == len - 1) begin
                checks++;
                if (bus.sramAddr !== exp_addr) begin
                    errors++;
                    $display("FAIL sramAddr addr=%h: got %h, required %h", addr, bus.sramAddr, exp_addr);
                end
`ifdef CACHE_STATS_EN
                checks++;
                if (bus.hitCount !== 16'(m_hits) || bus.missCount !== 16'(m_misses)) begin
                    errors++;
                    $display("FAIL stats addr=%h: got hit %0d miss %0d, required hit %0d miss %0d",
                             addr, bus.hitCount, bus.missCount, m_hits, m_misses);
                end
`endif
            end
            if (!hit && n == 9 + d) begin
                bus.refillAck = 1'b1;
                if (flush_at_ack) bus.flush = 1'b1;
            end
            if (n == 10 + d) begin
                bus.refillAck = 1'b0;
                bus.flush     = 1'b0;
            end
            if (n == reset_at) begin
                reset = 1'b1;
                #1;
                model_reset();
                check_reset_values("reset_mid_req");
                @(negedge fpgaClk);
                bus.refillAck = 1'b0;
                reset = 1'b0;
                return;
            end
        end

        if (!hit) begin
            if (flush_at_ack) model_flush();
            else if (used_ptr) m_ptr = (m_ptr + 1) % int'(ENTRIES);
            m_valid[slot] = 1'b1;
            m_tag[slot]   = tag;
        end
        @(negedge fpgaClk);
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.a         = '0;
        bus.flush     = 1'b0;
        bus.refillAck = 1'b0;
        model_reset();
        repeat (3) @(negedge fpgaClk);
        check_reset_values("reset");
        reset = 1'b0;
    endtask

    task automatic test_first_miss();
        access(24'h000C05, 4, 1'b0, 1'b0, -1);
        checks++;
        if (!m_valid[0] || m_tag[0] !== 14'h0003) begin
            errors++;
            $display("FAIL first_miss_slot: model slot0 valid %b tag %h, required 1/0003", m_valid[0], m_tag[0]);
        end
    endtask

    task automatic test_hit_repeat();
        access(24'h000F00, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_fill_evict();
        for (int k = 0; k < 8; k++) access({14'h0010 + 14'(k), 10'(k * 3)}, k % 3, k == 0, 1'b0, -1);
        access({14'h0018, 10'h011}, 1, 1'b0, 1'b0, -1);
        access({14'h0019, 10'h022}, 0, 1'b0, 1'b0, -1);
        access({14'h0010, 10'h033}, 2, 1'b0, 1'b0, -1);
        access({14'h0013, 10'h044}, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_flush_ack();
        access({14'h0042, 10'h2AA}, 2, 1'b1, 1'b1, -1);
        access({14'h0042, 10'h155}, 0, 1'b0, 1'b0, -1);
        access({14'h0043, 10'h001}, 1, 1'b0, 1'b0, -1);
        access({14'h0011, 10'h3FF}, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            access({14'h0100 + 14'($urandom_range(0, 11)), 10'($urandom)},
                   int'($urandom_range(0, 5)),
                   $urandom_range(0, 9) == 0,
                   $urandom_range(0, 7) == 0, -1);
        end
    endtask

    task automatic test_reset_mid_req();
        access({14'h0777, 10'h123}, 5, 1'b0, 1'b0, 11);
        access({14'h0005, 10'h001}, 1, 1'b0, 1'b0, -1);
        access({14'h0006, 10'h002}, 0, 1'b0, 1'b0, -1);
        access({14'h0777, 10'h003}, 3, 1'b0, 1'b0, -1);
        access({14'h0005, 10'h004}, 0, 1'b0, 1'b0, -1);
        access({14'h0006, 10'h005}, 0, 1'b0, 1'b0, -1);
`ifdef CACHE_STATS_EN
        checks++;
        if (bus.missCount !== 16'd3 || bus.hitCount !== 16'd2) begin
            errors++;
            $display("FAIL stats_after_reset: got miss %0d hit %0d, required 3/2", bus.missCount, bus.hitCount);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_hit_repeat();
        test_fill_evict();
        test_flush_ack();
        test_random();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/page_cache_mmu.md
# page_cache_mmu

Parametrised successor to the fixed four-page cache sequencer. It generates the CPU `phi2` clock from `fpgaClk` with a configurable phase length, and latches the CPU address each bus cycle. It looks the page tag up in an N-entry fully associative page table and drives the SRAM slot address on a hit. On a miss it stretches the cycle (`phi2` held high) and runs a refill handshake toward the external page loader, replacing entries round-robin. It sits between the CPU bus and the on-board cache SRAM.

## Interface
- `ENTRIES`, 8: cache page slots; power of two, at least 2; `IDX_W = $clog2(ENTRIES)`.
- `ADDR_W`, 24: CPU address width.
- `PAGE_W`, 10: in-page offset bits; `TAG_W = ADDR_W-PAGE_W`.
- `CYCLE_LEN`, 10: `fpgaClk` cycles per bus cycle.
- `PHI2_LOW_LEN`, 5: phases with `phi2` low.
- `LATCH_AT`, 7: phase at which the address is latched; `PHI2_LOW_LEN <= LATCH_AT <= CYCLE_LEN-3`.

Ports:
- `fpgaClk` in 1: the only clock.
- `reset` in 1: asynchronous, active-high.
- `a` in ADDR_W: CPU address.
- `flush` in 1: one-cycle pulse; invalidates all entries.
- `phi2` out 1: CPU clock.
- `sramEn` out 1: SRAM access enable.
- `sramAddr` out IDX_W+PAGE_W: {slot, offset}.
- `refillReq` out 1: refill request.
- `refillTag` out TAG_W: page to load.
- `refillSlot` out IDX_W: destination slot.
- `refillAck` in 1: loader done; sampled only while `refillReq`=1.
- `hitCount`, `missCount` out 16 each: present only with `CACHE_STATS_EN`.

## Operation
- Phase counter `phase` runs 0..CYCLE_LEN-1 and wraps to 0. `phi2` = (`phase` >= PHI2_LOW_LEN), registered.
- The table holds `ENTRIES` × {valid, tag}. Reset: all invalid, victim pointer 0.
- Phase LATCH_AT: register `a`.
- Phase LATCH_AT+1 (LOOKUP): compare the latched tag against all valid entries. Hit: register the slot index; `phase` advances. On multiple matches (impossible by construction) the lowest index wins.
- Miss: `phase` freezes at LOOKUP and the FSM moves RUN → REQ.
  - REQ: `refillReq`=1, `refillTag` = latched tag, `refillSlot` = victim. The slot is chosen as the lowest invalid slot if any exists, otherwise the victim pointer. All three are stable until ack.
  - On a cycle with `refillAck`=1: write tag to the slot, mark it valid, and advance the victim pointer (mod ENTRIES) only if the pointer was used. Go REQ → RUN and re-execute LOOKUP, which now hits.
- `sramEn`=1 for phases LOOKUP+1..CYCLE_LEN-1 of a hit cycle. `sramAddr` = {slot, latched a[PAGE_W-1:0]}, held until the next LATCH_AT.
- `flush`: clears all valid bits and the victim pointer in the next cycle.
  - Same cycle as `refillAck`: the flush is applied, then the installed entry is set valid.
  - During REQ without ack: the request continues unchanged.

## Timing
- Reset values: `phase`=0, `phi2`=0, `sramEn`=0, `sramAddr`=0, `refillReq`=0, `refillTag`=0, `refillSlot`=0, counters 0, FSM=RUN.
- Hit latency: address latch to `sramEn` = 2 `fpgaClk` cycles.
- Miss: `refillReq` rises 1 cycle after LOOKUP. It falls in the cycle after ack is sampled. LOOKUP repeats the next cycle and `sramEn` follows 1 cycle later.
- A miss stretches the bus cycle by (ack wait + 3) cycles. `phi2` stays high throughout.
- A reset mid-refill drops `refillReq` immediately (async) and restarts at phase 0.

## Configuration
- `CACHE_STATS_EN` defined:
  - `hitCount` increments on first-attempt hits at LOOKUP.
  - `missCount` increments on each miss at LOOKUP; the post-refill re-lookup is not counted.
  - Both saturate at 16'hFFFF; `flush` does not clear them.
- Undefined: the counters and their ports are absent.

## Structure
- Package `nova_mmu_pkg`: FSM state enum (RUN, REQ) and the default parameter constants.
- Sub-module `page_tag_cam`: the valid/tag array with a parallel compare, one-hot to index encoding, install and flush ports. The sequencer, FSM and counters live in the top.

## Test plan
- Reset, no access: `phi2` = 0 for phases 0–4 and 1 for phases 5–9, period 10; `refillReq` stays 0.
- First access `a`=24'h000C05: miss, `refillTag`=14'h0003, `refillSlot`=0. Ack after 4 cycles. `sramEn` then rises with `sramAddr`={3'd0,10'h005}.
- Repeat `a`=24'h000F00: hit, no stretch, `sramAddr`={0,10'h300}, bus cycle exactly 10 clocks.
- Fill 8 distinct pages, then a 9th: `refillSlot`=0, followed by 1 for the 10th; the evicted tag now misses.
- `flush` asserted in the same cycle as `refillAck` for tag 14'h0042: afterward only slot 0 (tag 14'h0042) is valid, and the next miss uses slot 1.
- `reset` asserted mid-REQ: `refillReq`=0 at once, all outputs at reset values, and the next access misses. With `CACHE_STATS_EN`, 3 misses plus 2 hits read `missCount`=3, `hitCount`=2.
